// File: rtl/pulse_train_generator.sv
// pulse_train_generator: programmable gated train of N pulses with H-cycle high and L-cycle low phases.
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_start, i_abort              one-cycle start (idle only) and abort strobes
//   i_high_cycles, i_low_cycles   phase durations in cycles (0 behaves as 1)
//   i_num_pulses                  pulses per train (0 = continuous until abort)
//   o_signal                      registered pulse output
//   o_gate, o_busy                high while a train is active
//   o_done                        one-cycle strobe when a finite train completes
//   o_pulse_count                 pulses completed in the current or last train
// Build option PULSE_TRAIN_EXT_TRIGGER_EN adds i_trigger, an asynchronous start source
// that is synchronised and rising-edge detected.
module pulse_train_generator #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
`ifdef PULSE_TRAIN_EXT_TRIGGER_EN
    input  logic             i_trigger,
`endif
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_high_cycles,
    input  logic [CNT_W-1:0] i_low_cycles,
    input  logic [CNT_W-1:0] i_num_pulses,
    output logic             o_signal,
    output logic             o_gate,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pulse_count
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, high_q, high_d, low_q, low_d, num_q, num_d, pc_q, pc_d;
    logic sig_q, sig_d, done_q, done_d;
    logic start;
`ifdef PULSE_TRAIN_EXT_TRIGGER_EN
    logic sync1_q, sync2_q, prev_q;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= i_trigger;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end
    assign start = i_start | (sync2_q & ~prev_q);
`else
    assign start = i_start;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        low_d   = low_q;
        num_d   = num_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        if (i_abort) begin
            // abort beats start and leaves the pulse count untouched
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    high_d  = (i_high_cycles == '0) ? CNT_W'(1) : i_high_cycles;
                    low_d   = (i_low_cycles == '0) ? CNT_W'(1) : i_low_cycles;
                    num_d   = i_num_pulses;
                    pc_d    = '0;
                end
                HIGH: if (cnt_q == high_q - CNT_W'(1)) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    pc_d    = pc_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                LOW: if (cnt_q == low_q - CNT_W'(1)) begin
                    cnt_d   = '0;
                    done_d  = (num_q != '0) && (pc_q == num_q);
                    state_d = done_d ? IDLE : HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
        sig_d = (state_d == HIGH);
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            num_q   <= '0;
            pc_q    <= '0;
            sig_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            low_q   <= low_d;
            num_q   <= num_d;
            pc_q    <= pc_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
        end
    end
    assign o_signal      = sig_q;
    assign o_gate        = (state_q != IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_done        = done_q;
    assign o_pulse_count = pc_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: directed self-checking bench for pulse_train_generator.
module tb_pulse_train_generator;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_high_cycles = '0;
    logic [31:0] i_low_cycles = '0;
    logic [31:0] i_num_pulses = '0;
    logic        o_signal, o_gate, o_busy, o_done;
    logic [31:0] o_pulse_count;
    logic [63:0] sig, gate;
    int          total = 0;
    int          bad = 0;
`ifdef PULSE_TRAIN_EXT_TRIGGER_EN
    logic        i_trigger = 1'b0;
`endif
    pulse_train_generator #(.CNT_W(32)) dut (
        .i_clk(clk),
        .i_rstn(rstn),
`ifdef PULSE_TRAIN_EXT_TRIGGER_EN
        .i_trigger(i_trigger),
`endif
        .i_start(i_start),
        .i_abort(i_abort),
        .i_high_cycles(i_high_cycles),
        .i_low_cycles(i_low_cycles),
        .i_num_pulses(i_num_pulses),
        .o_signal(o_signal),
        .o_gate(o_gate),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_pulse_count(o_pulse_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] pat(input int n, input int h, input int l);
        pat = '0;
        for (int i = 0; i < n; i++) pat[i] = (i % (h + l)) < h;
    endfunction
    function automatic logic [63:0] ones(input int n);
        ones = (64'd1 << n) - 64'd1;
    endfunction
    // called at a negedge; returns at the negedge after the start edge (sample 0)
    task automatic kick(input int h, input int l, input int n);
        i_high_cycles = h;
        i_low_cycles  = l;
        i_num_pulses  = n;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask
    // records n samples; optionally strobes start (with a new high time) or abort after sample ps/pa
    task automatic run(input int n, input int ps, input int pa, output logic [63:0] s, output logic [63:0] g);
        s = '0;
        g = '0;
        for (int i = 0; i < n; i++) begin
            i_start = 1'b0;
            i_abort = 1'b0;
            s[i] = o_signal;
            g[i] = o_gate;
            if (i == ps) begin
                i_start = 1'b1;
                i_high_cycles = 7;
            end
            if (i == pa) i_abort = 1'b1;
            @(negedge clk);
        end
        i_start = 1'b0;
        i_abort = 1'b0;
    endtask
    task automatic finish_checks(input string tag, input int pc);
        check({tag, "_done"}, 64'(o_done), 64'd1);
        check({tag, "_gate_off"}, 64'(o_gate), 64'd0);
        check({tag, "_busy_off"}, 64'(o_busy), 64'd0);
        check({tag, "_count"}, 64'(o_pulse_count), 64'(pc));
        @(negedge clk);
        check({tag, "_done_once"}, 64'(o_done), 64'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_sig", 64'(o_signal), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_count", 64'(o_pulse_count), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        kick(3, 2, 4);
        run(20, -1, -1, sig, gate);
        check("t1_sig", sig, pat(20, 3, 2));
        check("t1_gate", gate, ones(20));
        finish_checks("t1", 4);
        kick(0, 0, 2);
        run(4, -1, -1, sig, gate);
        check("t2_sig", sig, pat(4, 1, 1));
        check("t2_gate", gate, ones(4));
        finish_checks("t2", 2);
        kick(5, 5, 0);
        run(23, -1, 22, sig, gate);
        check("t3_sig", sig, pat(23, 5, 5));
        check("t3_gate", gate, ones(23));
        check("t3_sig_off", 64'(o_signal), 64'd0);
        check("t3_gate_off", 64'(o_gate), 64'd0);
        check("t3_busy_off", 64'(o_busy), 64'd0);
        check("t3_no_done", 64'(o_done), 64'd0);
        check("t3_count", 64'(o_pulse_count), 64'd2);
        @(negedge clk);
        check("t3_still_idle", 64'(o_busy), 64'd0);
        kick(2, 2, 3);
        run(12, 5, -1, sig, gate);
        check("t4_sig", sig, pat(12, 2, 2));
        check("t4_gate", gate, ones(12));
        finish_checks("t4", 3);
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        check("t5_sa_busy", 64'(o_busy), 64'd0);
        check("t5_sa_sig", 64'(o_signal), 64'd0);
        kick(2, 3, 2);
        run(3, -1, -1, sig, gate);
        check("t5_pre_gate", 64'(o_gate), 64'd1);
        check("t5_pre_sig", 64'(o_signal), 64'd0);
        #1 rstn = 1'b0;
        #1;
        check("t5_rst_gate", 64'(o_gate), 64'd0);
        check("t5_rst_busy", 64'(o_busy), 64'd0);
        check("t5_rst_count", 64'(o_pulse_count), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        kick(1, 1, 1);
        run(2, -1, -1, sig, gate);
        check("t5_sig", sig, pat(2, 1, 1));
        finish_checks("t5", 1);
`ifdef PULSE_TRAIN_EXT_TRIGGER_EN
        i_high_cycles = 1;
        i_low_cycles  = 1;
        i_num_pulses  = 1;
        i_trigger = 1'b1;
        @(negedge clk);
        check("t6_lat1", 64'(o_signal), 64'd0);
        @(negedge clk);
        check("t6_lat2", 64'(o_signal), 64'd0);
        @(negedge clk);
        check("t6_lat3", 64'(o_signal), 64'd1);
        @(negedge clk);
        check("t6_low", 64'(o_signal), 64'd0);
        finish_checks("t6", 1);
        kick(6, 6, 1);
        i_trigger = 1'b0;
        repeat (2) @(negedge clk);
        i_trigger = 1'b1;
        repeat (10) @(negedge clk);
        finish_checks("t6b", 1);
        repeat (4) @(negedge clk);
        check("t6b_no_restart", 64'(o_busy), 64'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
